// File: rtl/eu_icon_txq_pkg.sv
// Shared data types for the execution-unit interconnect transmit queue.
// Consumed by eu_icon_txq (optional same-cycle bypass: ICON_TXQ_BYPASS_EN).
package eu_icon_txq_pkg;

  localparam int LOG2_NUM_EXEC_UNITS = 2;
  localparam int EU_OFFS_W           = 6;
  localparam int EU_DATA_W           = 16;
  localparam int ICON_TXQ_DEPTH      = 4;

  typedef struct packed {
    logic [LOG2_NUM_EXEC_UNITS-1:0] euidx;
    logic [EU_OFFS_W-1:0]           offs;
  } type_exec_unit_addr;

  typedef logic [EU_DATA_W-1:0] type_exec_unit_data;

  typedef struct packed {
    type_exec_unit_data opd_data;
    type_exec_unit_addr opd_addr;
    logic               opd_opx;
    logic               opd_valid;
  } type_alu_channel_tx;

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
    logic               valid;
  } type_icon_tx_channel;

  typedef struct packed {
    logic success;
  } type_icon_rx_channel;

  typedef struct packed {
    logic               opx;
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } type_icon_txq_entry;

  typedef enum logic {
    TXQ_IDLE    = 1'b0,
    TXQ_PRESENT = 1'b1
  } type_txq_state;

endpackage

// File: rtl/eu_icon_txq_fifo_sync.sv
// Synchronous FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Pushes while full and pops while empty are ignored.
module eu_icon_txq_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage is intentionally unreset; contents are only observed behind count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eu_icon_txq.sv
// Transmit queue from the ALU result channel to the interconnect: buffers
// foreign-addressed results in order. Optional bypass: ICON_TXQ_BYPASS_EN.
module eu_icon_txq
  import eu_icon_txq_pkg::*;
#(
  parameter int                             DEPTH      = ICON_TXQ_DEPTH,
  parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX     = '0,
  parameter int                             WAIT_CNT_W = 8,
  localparam int                            CW         = $clog2(DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                reset,
  input  type_alu_channel_tx  i_alu_tx,
  output logic                o_alu_tx_ready,
  output type_icon_tx_channel o_icon_tx,
  output logic                o_icon_opx,
  input  type_icon_rx_channel i_icon_rx,
  output logic [CW-1:0]       o_count,
  output logic                o_full,
  output logic                o_empty,
  output logic [WAIT_CNT_W-1:0] o_head_wait
);

  type_txq_state      r_state;
  type_txq_state      w_state_next;
  logic [WAIT_CNT_W-1:0] r_head_wait;
  type_icon_txq_entry w_wr_entry;
  type_icon_txq_entry w_head;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_bypass;
  logic [CW-1:0]      w_count_next;

  assign w_push_req = i_alu_tx.opd_valid && (i_alu_tx.opd_addr.euidx != EU_IDX);

`ifdef ICON_TXQ_BYPASS_EN
  // Empty queue forwards the result straight to the link; if the link takes
  // it this cycle the entry never lands in storage.
  assign w_bypass = o_empty && w_push_req && !reset;
  assign w_push   = w_push_req && !o_full && !(w_bypass && i_icon_rx.success);
`else
  assign w_bypass = 1'b0;
  assign w_push   = w_push_req && !o_full;
`endif
  assign w_pop    = !o_empty && i_icon_rx.success;

  assign w_wr_entry.opx  = i_alu_tx.opd_opx;
  assign w_wr_entry.addr = i_alu_tx.opd_addr;
  assign w_wr_entry.data = i_alu_tx.opd_data;

  eu_icon_txq_fifo_sync #(
    .WIDTH ($bits(type_icon_txq_entry)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_data  (w_head),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  assign o_alu_tx_ready = !o_full;
  assign w_count_next   = o_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_state <= TXQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TXQ_IDLE: begin
        if (w_count_next != '0) begin
          w_state_next = TXQ_PRESENT;
        end
      end
      TXQ_PRESENT: begin
        if (w_count_next == '0) begin
          w_state_next = TXQ_IDLE;
        end
      end
      default: w_state_next = TXQ_IDLE;
    endcase
  end

  // Valid follows the presentation state, so reset drops it asynchronously.
  always_comb begin
    o_icon_tx.addr  = w_head.addr;
    o_icon_tx.data  = w_head.data;
    o_icon_tx.valid = (r_state == TXQ_PRESENT);
    o_icon_opx      = w_head.opx;
    if (w_bypass) begin
      o_icon_tx.addr  = i_alu_tx.opd_addr;
      o_icon_tx.data  = i_alu_tx.opd_data;
      o_icon_tx.valid = 1'b1;
      o_icon_opx      = i_alu_tx.opd_opx;
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_head_wait <= '0;
    end else if (w_pop || o_empty) begin
      r_head_wait <= '0;
    end else if (!i_icon_rx.success && (r_head_wait != '1)) begin
      r_head_wait <= r_head_wait + WAIT_CNT_W'(1);
    end
  end

  assign o_head_wait = r_head_wait;

endmodule

// File: tb/tb_eu_icon_txq.sv
// Directed bench for eu_icon_txq: filtering, FIFO order, full/wrap, head-wait
// saturation (WAIT_CNT_W=4), async reset, and the ICON_TXQ_BYPASS_EN path.
module tb_eu_icon_txq;
  import eu_icon_txq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WW    = 4;

  logic                clk;
  logic                rst;
  type_alu_channel_tx  alu_tx;
  logic                alu_ready;
  type_icon_tx_channel icon_tx;
  logic                icon_opx;
  type_icon_rx_channel icon_rx;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic [WW-1:0]       head_wait;

  int n_vec;
  int n_err;
  logic [15:0] exp_q[$];

  eu_icon_txq #(
    .DEPTH      (DEPTH),
    .EU_IDX     (2'd0),
    .WAIT_CNT_W (WW)
  ) dut (
    .i_clk          (clk),
    .reset          (rst),
    .i_alu_tx       (alu_tx),
    .o_alu_tx_ready (alu_ready),
    .o_icon_tx      (icon_tx),
    .o_icon_opx     (icon_opx),
    .i_icon_rx      (icon_rx),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty),
    .o_head_wait    (head_wait)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [1:0] eu, input logic [15:0] d,
                           input logic opx);
    alu_tx.opd_valid      = v;
    alu_tx.opd_addr.euidx = eu;
    alu_tx.opd_addr.offs  = 6'd3;
    alu_tx.opd_data       = d;
    alu_tx.opd_opx        = opx;
  endtask

  task automatic idle_alu();
    drive_alu(1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_foreign(input logic [1:0] eu, input logic [15:0] d);
    drive_alu(1'b1, eu, d, 1'b0);
    step();
    idle_alu();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle_alu();
    icon_rx.success = 1'b0;
    #2;
    check("rst_valid", 32'(icon_tx.valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ready", 32'(alu_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_wait", 32'(head_wait), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // 1: single foreign push, hold, then pop
    drive_alu(1'b1, 2'd2, 16'h00A5, 1'b1);
    step();
    idle_alu();
    check("t1_valid", 32'(icon_tx.valid), 32'd1);
    check("t1_euidx", 32'(icon_tx.addr.euidx), 32'd2);
    check("t1_data", 32'(icon_tx.data), 32'h00A5);
    check("t1_opx", 32'(icon_opx), 32'd1);
    check("t1_count", 32'(count), 32'd1);
    check("t1_wait0", 32'(head_wait), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("t1_wait5", 32'(head_wait), 32'd5);
    check("t1_stable_data", 32'(icon_tx.data), 32'h00A5);
    check("t1_stable_valid", 32'(icon_tx.valid), 32'd1);
    icon_rx.success = 1'b1;
    step();
    icon_rx.success = 1'b0;
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_valid_off", 32'(icon_tx.valid), 32'd0);
    check("t1_wait_clr", 32'(head_wait), 32'd0);

    // 2: local and invalid results are ignored
    drive_alu(1'b1, 2'd0, 16'h1111, 1'b0);
    step();
    drive_alu(1'b0, 2'd1, 16'h2222, 1'b0);
    step();
    idle_alu();
    check("t2_count", 32'(count), 32'd0);
    check("t2_valid", 32'(icon_tx.valid), 32'd0);

    // 3: fill, drop 5th, drain in order
    for (int i = 0; i < 4; i++) begin
      push_foreign(2'd1, 16'h0010 + 16'(i));
      exp_q.push_back(16'h0010 + 16'(i));
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_ready", 32'(alu_ready), 32'd0);
    check("t3_count4", 32'(count), 32'd4);
    push_foreign(2'd1, 16'h0014);
    check("t3_drop_count", 32'(count), 32'd4);
    icon_rx.success = 1'b1;
    while (exp_q.size() > 0) begin
      check("t3_order", 32'(icon_tx.data), 32'(exp_q.pop_front()));
      step();
    end
    icon_rx.success = 1'b0;
    check("t3_empty", 32'(empty), 32'd1);

    // 4: push+pop while full, while not full, then pointer wrap
    for (int i = 0; i < 4; i++) begin
      push_foreign(2'd3, 16'h0020 + 16'(i));
      exp_q.push_back(16'h0020 + 16'(i));
    end
    drive_alu(1'b1, 2'd3, 16'h0024, 1'b0);
    icon_rx.success = 1'b1;
    step();
    void'(exp_q.pop_front());
    check("t4_full_pp_count", 32'(count), 32'd3);
    check("t4_full_pp_ready", 32'(alu_ready), 32'd1);
    check("t4_full_pp_head", 32'(icon_tx.data), 32'(exp_q[0]));
    idle_alu();
    step();
    void'(exp_q.pop_front());
    check("t4_count2", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive_alu(1'b1, 2'd1, 16'h0030 + 16'(i), 1'b0);
      step();
      exp_q.push_back(16'h0030 + 16'(i));
      void'(exp_q.pop_front());
      check("t4_pp_count", 32'(count), 32'd2);
      check("t4_pp_head", 32'(icon_tx.data), 32'(exp_q[0]));
    end
    idle_alu();
    while (exp_q.size() > 0) begin
      check("t4_drain", 32'(icon_tx.data), 32'(exp_q.pop_front()));
      step();
    end
    icon_rx.success = 1'b0;
    check("t4_empty", 32'(empty), 32'd1);

    // 5: head-wait saturates at 15
    push_foreign(2'd3, 16'h0055);
    for (int i = 0; i < 20; i++) step();
    check("t5_wait_sat", 32'(head_wait), 32'd15);
    icon_rx.success = 1'b1;
    step();
    icon_rx.success = 1'b0;
    check("t5_empty", 32'(empty), 32'd1);

    // 6: async reset with three queued entries
    for (int i = 0; i < 3; i++) push_foreign(2'd2, 16'h0060 + 16'(i));
    check("t6_count3", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(icon_tx.valid), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("t6_post_count", 32'(count), 32'd0);
    check("t6_post_valid", 32'(icon_tx.valid), 32'd0);

    // bypass behaviour (or its absence) on a push into an empty queue
    drive_alu(1'b1, 2'd2, 16'h0077, 1'b0);
    icon_rx.success = 1'b1;
    #1;
`ifdef ICON_TXQ_BYPASS_EN
    check("byp_valid", 32'(icon_tx.valid), 32'd1);
    check("byp_data", 32'(icon_tx.data), 32'h0077);
    step();
    idle_alu();
    icon_rx.success = 1'b0;
    check("byp_count", 32'(count), 32'd0);
    check("byp_valid_after", 32'(icon_tx.valid), 32'd0);
`else
    check("nobyp_valid", 32'(icon_tx.valid), 32'd0);
    step();
    idle_alu();
    icon_rx.success = 1'b0;
    check("nobyp_count", 32'(count), 32'd1);
    check("nobyp_data", 32'(icon_tx.data), 32'h0077);
    icon_rx.success = 1'b1;
    step();
    icon_rx.success = 1'b0;
    check("nobyp_empty", 32'(empty), 32'd1);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
